fir_avg_pipe: RTL and testbench

FIR_AVG_PIPE -- requirements
Module: fir_avg_pipe

---
 rtl/fir_pkg.sv | 12 +
 rtl/wideDFF.sv | 24 ++
 rtl/fir_avg_pipe.sv | 86 ++++++++
 tb/tb_fir_avg_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and sizing helpers for the moving-average FIR.
package fir_pkg;

    localparam int unsigned DEF_WIDTH      = 24;
    localparam int unsigned DEF_LOG2_DEPTH = 3;

    // One guard bit above the sample width keeps the running sum from wrapping.
    function automatic int unsigned acc_width(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/wideDFF.sv
// Enable/reset register block: synchronous active-high reset, load on enable.
module wideDFF #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fir_avg_pipe.sv
// Moving average over the last 2**LOG2_DEPTH accepted samples, kept as a running
// accumulator updated with the pre-shifted newest and oldest samples.
module fir_avg_pipe
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] q,
    output logic signed [WIDTH-1:0] oldest,
    output logic                    filled,
    output logic                    out_valid
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned AW    = acc_width(WIDTH);
    localparam int unsigned CW    = LOG2_DEPTH + 1;

    logic signed [WIDTH-1:0] tap [DEPTH];
    logic                    flush;

    assign flush = reset | clear;

    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        if (i == 0) begin : g_head
            wideDFF #(.WIDTH(WIDTH)) u_tap (
                .clk_i(clk),
                .rst_i(flush),
                .en_i (en),
                .d_i  (d),
                .q_o  (tap[i])
            );
        end else begin : g_body
            wideDFF #(.WIDTH(WIDTH)) u_tap (
                .clk_i(clk),
                .rst_i(flush),
                .en_i (en),
                .d_i  (tap[i-1]),
                .q_o  (tap[i])
            );
        end
    end

    logic signed [WIDTH-1:0] d_sh;
    logic signed [WIDTH-1:0] last_sh;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [WIDTH-1:0] avg_q;
    logic        [CW-1:0]    cnt_q, cnt_d;
    logic                    valid_q;

    // Empty taps hold zero, so subtracting the last tap during fill is harmless.
    always_comb begin
        d_sh    = d >>> LOG2_DEPTH;
        last_sh = tap[DEPTH-1] >>> LOG2_DEPTH;
        acc_d   = acc_q + AW'(d_sh) - AW'(last_sh);
        cnt_d   = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q   <= '0;
            avg_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (en) begin
                acc_q   <= acc_d;
                avg_q   <= acc_d[WIDTH-1:0];
                cnt_q   <= cnt_d;
                valid_q <= (cnt_d == CW'(DEPTH));
            end
        end
    end

    assign q         = avg_q;
    assign oldest    = tap[DEPTH-1];
    assign filled    = (cnt_q == CW'(DEPTH));
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fir_avg_pipe.sv
// Scoreboard bench for fir_avg_pipe: a sample-history model predicts every cycle's outputs.
module tb_fir_avg_pipe;

    localparam int W = 24;
    localparam int L = 3;
    localparam int D = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic                clear = 1'b0;
    logic signed [W-1:0] d = '0;
    logic signed [W-1:0] q;
    logic signed [W-1:0] oldest;
    logic                filled;
    logic                out_valid;

    always #5 clk = ~clk;

    fir_avg_pipe #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (clear),
        .d        (d),
        .q        (q),
        .oldest   (oldest),
        .filled   (filled),
        .out_valid(out_valid)
    );

    typedef struct packed {
        logic signed [W-1:0] q;
        logic signed [W-1:0] oldest;
        logic                filled;
        logic                ov;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic signed [W-1:0] act, input logic signed [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // History model: newest first, at most D samples, unfilled slots count as zero.
    task automatic step(input logic r, input logic c, input logic e, input logic signed [W-1:0] dv);
        exp_t x;
        int   sum;
        @(negedge clk);
        reset = r;
        clear = c;
        en    = e;
        d     = dv;
        x.ov  = 1'b0;
        if (r || c) begin
            hist.delete();
        end else if (e) begin
            hist.push_front(int'(dv));
            if (hist.size() > D) void'(hist.pop_back());
            x.ov = (hist.size() == D);
        end
        sum = 0;
        foreach (hist[i]) sum += hist[i] >>> L;
        x.q      = W'(sum);
        x.oldest = (hist.size() == D) ? W'(hist[D-1]) : '0;
        x.filled = (hist.size() == D);
        sb.push_back(x);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", q, x.q);
                chk("oldest", oldest, x.oldest);
                chk1("filled", filled, x.filled);
                chk1("out_valid", out_valid, x.ov);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic signed [W-1:0] rv;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);

        for (int i = 0; i < D; i++) step(0, 0, 1, 24'sd800);
        #1;
        chk("fill_q800", q, 24'sd800);
        chk1("fill_filled", filled, 1'b1);

        for (int i = 0; i < D; i++) step(0, 0, 1, '0);
        #1;
        chk("drain_q0", q, '0);

        step(0, 1, 0, '0);
        step(0, 0, 1, -24'sd16);
        #1;
        chk("neg16_q", q, -24'sd2);
        chk("neg16_oldest", oldest, '0);
        step(0, 0, 1, -24'sd1);
        #1;
        chk("neg1_floor_q", q, -24'sd3);

        for (int i = 0; i < 16; i++) begin
            rv = W'($urandom);
            step(0, 0, (i % 4 == 0) || (i % 4 == 3), rv);
        end

        step(0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, W'($urandom_range(0, 4000)));
        step(0, 1, 1, 24'sd500);
        #1;
        chk("clear_q0", q, '0);
        chk1("clear_filled", filled, 1'b0);
        for (int i = 0; i < D; i++) step(0, 0, 1, W'($urandom_range(0, 4000)));

        step(0, 0, 1, 24'sd1234);
        step(1, 0, 1, 24'sd777);
        #1;
        chk("reset_q0", q, '0);
        for (int i = 0; i < D - 1; i++) step(0, 0, 1, W'($urandom));
        #1;
        chk1("refill_not_yet", filled, 1'b0);
        step(0, 0, 1, W'($urandom));
        #1;
        chk1("refill_done", filled, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rv = W'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 7, rv);
        end

        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
